// File: rtl/pager_pkg.sv
// result_pager shared constants: page encodings, flag layout, indicator codes.
package pager_pkg;

    typedef logic [1:0] page_t;

    localparam page_t PAGE_C = 2'd0;
    localparam page_t PAGE_A = 2'd1;
    localparam page_t PAGE_B = 2'd2;
    localparam page_t PAGE_F = 2'd3;

    localparam int FLAG_W = 5;
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    localparam logic [3:0] ONEHOT_C = 4'b1000;
    localparam logic [3:0] ONEHOT_A = 4'b0100;
    localparam logic [3:0] ONEHOT_B = 4'b0010;
    localparam logic [3:0] ONEHOT_F = 4'b0001;

    function automatic logic [3:0] page_to_onehot(input page_t p);
        logic [3:0] oh;
        oh = ONEHOT_C;
        unique case (p)
            PAGE_C: oh = ONEHOT_C;
            PAGE_A: oh = ONEHOT_A;
            PAGE_B: oh = ONEHOT_B;
            PAGE_F: oh = ONEHOT_F;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/result_pager_tc_counter.sv
// Terminal-count counter: counts 0..N-1 while enabled, pulses tc on N-1 and wraps.
module tc_counter #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    assign tc = en && (count == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/result_pager.sv
// Snapshot A/B/C/flags on snap and page them onto the 16-bit hex display.
// Optional auto-scroll is built when RESULT_PAGER_AUTO_SCROLL_EN is defined.
module result_pager
    import pager_pkg::*;
#(
    parameter int SCROLL_CYCLES = 100_000_000,
    parameter int FRESH_CYCLES  = 25_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              snap,
    input  logic              step,
    input  logic [15:0]       a_in,
    input  logic [15:0]       b_in,
    input  logic [15:0]       c_in,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [15:0]       value,
    output logic [1:0]        page,
    output logic [3:0]        page_onehot,
    output logic              snap_valid,
    output logic              fresh
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]        state;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [15:0]       c_q;
    logic [FLAG_W-1:0] f_q;
    page_t             page_q;
    logic              fresh_q;
    logic              fresh_tc;
    logic              scroll_tc;
    logic              show;
    logic              advance;

    assign show    = (state == ST_SHOW);
    // snap has priority: a coincident step or dwell expiry is dropped
    assign advance = show && !snap && (step || scroll_tc);

    tc_counter #(.N(FRESH_CYCLES)) u_fresh (
        .clk   (CLOCK_50),
        .reset (reset),
        .clear (snap),
        .en    (fresh_q),
        .tc    (fresh_tc)
    );

`ifdef RESULT_PAGER_AUTO_SCROLL_EN
    tc_counter #(.N(SCROLL_CYCLES)) u_scroll (
        .clk   (CLOCK_50),
        .reset (reset),
        .clear (snap || step),
        .en    (show),
        .tc    (scroll_tc)
    );
`else
    assign scroll_tc = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            f_q     <= '0;
            page_q  <= PAGE_C;
            fresh_q <= 1'b0;
        end else if (snap) begin
            state   <= ST_SHOW;
            a_q     <= a_in;
            b_q     <= b_in;
            c_q     <= c_in;
            f_q     <= flags_in;
            page_q  <= PAGE_C;
            fresh_q <= 1'b1;
        end else begin
            if (advance) begin
                page_q <= page_q + 2'd1;
            end
            if (fresh_tc) begin
                fresh_q <= 1'b0;
            end
        end
    end

    always_comb begin
        value = '0;
        if (show) begin
            unique case (page_q)
                PAGE_C: value = c_q;
                PAGE_A: value = a_q;
                PAGE_B: value = b_q;
                PAGE_F: value = {{(16 - FLAG_W){1'b0}}, f_q};
            endcase
        end
    end

    assign page        = page_q;
    assign page_onehot = page_to_onehot(page_q);
    assign snap_valid  = show;
    assign fresh       = fresh_q;

endmodule

// File: tb/tb_result_pager.sv
// Directed bench for result_pager (SCROLL_CYCLES=8, FRESH_CYCLES=4).
// Auto-scroll checks run when RESULT_PAGER_AUTO_SCROLL_EN is defined.
module tb_result_pager;

    logic        clk = 1'b0;
    logic        reset;
    logic        snap;
    logic        step;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] c_in;
    logic [4:0]  flags_in;
    logic [15:0] value;
    logic [1:0]  page;
    logic [3:0]  page_onehot;
    logic        snap_valid;
    logic        fresh;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    result_pager #(
        .SCROLL_CYCLES (8),
        .FRESH_CYCLES  (4)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .snap        (snap),
        .step        (step),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .flags_in    (flags_in),
        .value       (value),
        .page        (page),
        .page_onehot (page_onehot),
        .snap_valid  (snap_valid),
        .fresh       (fresh)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; snap = 1'b0; step = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; flags_in = '0;
        tick();
        reset = 1'b0;
        chk("rst value", value, 16'h0000);
        chk("rst page", 16'(page), 16'd0);
        chk("rst onehot", 16'(page_onehot), 16'h8);
        chk("rst valid", 16'(snap_valid), 16'd0);
        chk("rst fresh", 16'(fresh), 16'd0);

        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
            chk("empty value", value, 16'h0000);
            chk("empty page", 16'(page), 16'd0);
            chk("empty valid", 16'(snap_valid), 16'd0);
        end

        a_in = 16'h1234; b_in = 16'h00FF; c_in = 16'h1333; flags_in = 5'b00001;
        snap = 1'b1; tick(); snap = 1'b0;
        c_in = 16'hBEEF;
        chk("snap value", value, 16'h1333);
        chk("snap onehot", 16'(page_onehot), 16'h8);
        chk("snap valid", 16'(snap_valid), 16'd1);
        chk("fresh t1", 16'(fresh), 16'd1);
        tick(); chk("fresh t2", 16'(fresh), 16'd1);
        tick(); chk("fresh t3", 16'(fresh), 16'd1);
        tick(); chk("fresh t4", 16'(fresh), 16'd1);
        tick(); chk("fresh t5", 16'(fresh), 16'd0);
        chk("hold C", value, 16'h1333);

        step = 1'b1;
        tick(); chk("pg1 value", value, 16'h1234);
        chk("pg1 onehot", 16'(page_onehot), 16'h4);
        tick(); chk("pg2 value", value, 16'h00FF);
        chk("pg2 onehot", 16'(page_onehot), 16'h2);
        tick(); chk("pg3 value", value, 16'h0001);
        chk("pg3 onehot", 16'(page_onehot), 16'h1);
        tick(); chk("wrap value", value, 16'h1333);
        chk("wrap page", 16'(page), 16'd0);
        tick(2);
        step = 1'b0;
        chk("back pg2", 16'(page), 16'd2);

        a_in = 16'hAAAA; c_in = 16'h5555;
        snap = 1'b1; step = 1'b1; tick(); snap = 1'b0; step = 1'b0;
        chk("snapstep page", 16'(page), 16'd0);
        chk("snapstep value", value, 16'h5555);
        chk("resnap fresh", 16'(fresh), 16'd1);
        step = 1'b1; tick(); step = 1'b0;
        chk("new A", value, 16'hAAAA);

        reset = 1'b1; snap = 1'b1; step = 1'b1; tick();
        reset = 1'b0; snap = 1'b0; step = 1'b0;
        chk("mid rst value", value, 16'h0000);
        chk("mid rst page", 16'(page), 16'd0);
        chk("mid rst onehot", 16'(page_onehot), 16'h8);
        chk("mid rst valid", 16'(snap_valid), 16'd0);
        chk("mid rst fresh", 16'(fresh), 16'd0);

        a_in = 16'h0001; b_in = 16'h0002; c_in = 16'h0003; flags_in = 5'h1F;
        snap = 1'b1; tick(); snap = 1'b0;
        chk("s2 value", value, 16'h0003);
`ifdef RESULT_PAGER_AUTO_SCROLL_EN
        for (int p = 1; p <= 4; p++) begin
            tick(7);
            chk("dwell hold", 16'(page), 16'((p - 1) % 4));
            tick();
            chk("dwell adv", 16'(page), 16'(p % 4));
        end
        tick(5);
        step = 1'b1; tick(); step = 1'b0;
        chk("step in dwell", 16'(page), 16'd1);
        tick(7);
        chk("restart hold", 16'(page), 16'd1);
        tick();
        chk("restart adv", 16'(page), 16'd2);
        chk("restart value", value, 16'h0002);
`else
        tick(100);
        chk("no scroll page", 16'(page), 16'd0);
        chk("no scroll value", value, 16'h0003);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/result_pager.md
# result_pager

Readout-side companion to the switch-entry path. It captures a snapshot of operand A, operand B, ALU result C and the ALU flags on a commit pulse, then pages through them one at a time onto the existing 16-bit four-digit hex display path. Paging is driven by a debounced step pulse and, optionally, by an auto-scroll timer. It sits between the ALU/operand registers and the `hex4` display instance; the page indicator drives LEDR.

## Interface
Parameters:
- `SCROLL_CYCLES`, default 100_000_000: auto-scroll dwell per page in clocks (2 s @ 50 MHz); must be ≥ 2.
- `FRESH_CYCLES`, default 25_000_000: length of the `fresh` indication after a snapshot; must be ≥ 2.

Ports:
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `snap`  in  1  one-cycle pulse: capture inputs and restart at page 0.
- `step`  in  1  one-cycle pulse (already debounced): advance one page.
- `a_in`  in  16  operand A.
- `b_in`  in  16  operand B.
- `c_in`  in  16  ALU result C.
- `flags_in`  in  5  ALU flags {Z,C,O,L,N}, bit 4 = Z.
- `value`  out  16  word to display.
- `page`  out  2  current page index.
- `page_onehot`  out  4  page indicator: 1000=C, 0100=A, 0010=B, 0001=Flags.
- `snap_valid`  out  1  at least one snapshot taken since reset.
- `fresh`  out  1  high for `FRESH_CYCLES` clocks after a snapshot.

## Operation
- States: EMPTY (no snapshot) and SHOW. Reset → EMPTY.
- Reset values: `value`=0, `page`=0, `page_onehot`=1000, `snap_valid`=0, `fresh`=0. Shadow registers and counters cleared.
- EMPTY: `step` is ignored, `value`=0, and no timers run. `snap` captures the inputs and moves to SHOW.
- SHOW: `value` is selected by `page`: 0 → C, 1 → A, 2 → B, 3 → {11'b0, flags}.
- `step` sets page = page+1 mod 4 (3 → 0 wrap) and clears the scroll counter.
- `snap` in SHOW recaptures all four shadow registers, forces page 0, clears the scroll counter and reloads the fresh counter.
- Same-cycle `snap` and `step`: `snap` wins and `step` is dropped.
- Same-cycle `step` and scroll terminal count: page advances exactly one.
- Shadow registers are written only on `snap`. Input changes at other times have no effect on `value`.
- `fresh`: the down-counter is loaded with `FRESH_CYCLES` on `snap`. `fresh` = (counter ≠ 0), and the counter decrements each clock until it reaches 0.
- Counter widths are `$clog2` of their parameter. No arithmetic overflow is possible.
- `reset` asserted mid-operation returns everything to reset values on the next edge, regardless of `snap`/`step`.

## Timing
- `snap` high at edge t: at t+1 the shadows hold the inputs sampled at t, `page`=0, `value`=C, `snap_valid`=1, `fresh`=1.
- `fresh` falls at t+1+`FRESH_CYCLES` unless re-snapped.
- `step` high at edge t: `page` and `page_onehot` update at t+1, and `value` follows in the same cycle (combinational mux of registered shadows and page).
- Back-to-back `step` pulses on consecutive cycles each advance one page.
- All outputs are registered or are pure functions of registers. There is no input-to-output combinational path.

## Configuration
- `RESULT_PAGER_AUTO_SCROLL_EN` defined: in SHOW, the scroll counter counts every clock. On reaching `SCROLL_CYCLES`-1 it advances the page by one, wrapping, and clears. Any `step` or `snap` restarts the dwell.
- Not defined: no scroll counter is built, and the page changes only on `step` and `snap`.

## Structure
- Shared package `pager_pkg` holds:
  - the page encodings `PAGE_C`=0, `PAGE_A`=1, `PAGE_B`=2, `PAGE_F`=3;
  - the flag width 5 and the flag bit positions (Z=4, C=3, O=2, L=1, N=0);
  - the one-hot indicator constants.
- One sub-module, `tc_counter`:
  - parameterised terminal-count counter with clear/load, enable and a terminal-count pulse;
  - instantiated for the fresh timer and, under the macro, the scroll timer.

## Test plan
Bench parameters: `SCROLL_CYCLES`=8, `FRESH_CYCLES`=4.
- Reset, then `step` ×3 with no `snap` → `value`=0000, `page`=0, `snap_valid`=0 throughout.
- Snap with A=1234, B=00FF, C=1333, flags=00001 → next cycle `value`=1333 and `page_onehot`=1000. After `step` ×3, `value` is 1234, then 00FF, then 0001. A 4th `step` wraps to 1333.
- Change `c_in` to BEEF after the snap without a new snap → `value` stays 1333. `fresh` is high for exactly 4 cycles after the snap.
- Assert `snap` and `step` in the same cycle while on page 2 → `page`=0 with the new capture shown and no advance. Assert `reset` during SHOW → all outputs return to reset values next cycle.
- With the macro defined, idle after snap → page advances every 8 cycles, 0→1→2→3→0. A `step` at dwell cycle 5 advances once and restarts the 8-cycle dwell.
- With the macro undefined, idle for 100 cycles after snap → `page` stays 0.
